serial_cmp_sched: RTL and testbench
===================================

SERIAL_CMP_SCHED -- requirements
Module: serial_cmp_sched

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the operand width in bits (legal range 2..32).
REQ-002 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  SHALL be the reset: asynchronous assertion, active-low.
REQ-004 req0_valid  input  1  SHALL indicate that requester 0 presents an operand pair.
REQ-005 req0_a, req0_b  input  WIDTH each  SHALL be the requester 0 operands, unsigned.
REQ-006 req0_ready  output  1  SHALL indicate that requester 0's pair is accepted this cycle.
REQ-007 req1_valid, req1_a, req1_b, req1_ready SHALL mirror REQ-004..006 for requester 1.
REQ-008 res_valid  output  1  SHALL be a one-cycle pulse marking a valid result.
REQ-009 res_id  output  1  SHALL identify the requester that owns the result.
REQ-010 res_gt, res_lt, res_eq  output  1 each  SHALL give a>b, a<b and a==b for the owning request; exactly one is high when res_valid=1.

Function
REQ-011 The block SHALL time-share one internal 1-bit comparator (gt/lt/eq of a single bit pair) between both requesters and scan the operands serially, MSB first.
REQ-012 FSM states SHALL be IDLE, RUN and DONE.
REQ-013 IDLE: if either valid is high, the block SHALL assert exactly one ready combinationally, latch that requester's a, b and id, load the bit index with WIDTH-1, and go to RUN at the next edge.
REQ-014 Arbitration SHALL be round-robin: if both valids are high, the requester not granted last SHALL win; a lone valid SHALL always win.
REQ-015 The last-grant register SHALL reset to 1, so requester 0 wins the first tie.
REQ-016 ready SHALL be low in RUN and DONE; valid held during those states SHALL NOT be accepted.
REQ-017 RUN: each cycle, the block SHALL compare bit[index] of the latched a and b.
REQ-018 RUN, on the first differing bit: gt/lt SHALL be latched as the result and the FSM SHALL go to DONE (early termination).
REQ-019 RUN, bits equal and index 0: eq SHALL be latched and the FSM SHALL go to DONE.
REQ-020 RUN, bits equal and index > 0: the index SHALL decrement and the FSM SHALL stay in RUN.
REQ-021 Latency: with k the number of bits examined (1..WIDTH), res_valid SHALL be high in the cycle k+1 edges after the accepting edge.
REQ-022 DONE: res_valid SHALL be high for exactly one cycle and the FSM SHALL return to IDLE; the earliest next acceptance is the cycle after DONE.
REQ-023 res_id, res_gt, res_lt and res_eq SHALL hold their values until the next DONE; outside DONE, res_valid SHALL be 0.
REQ-024 Operand changes on the inputs after acceptance SHALL NOT affect the result in progress.
REQ-025 The block SHALL have no output backpressure; results SHALL be dropped only if the consumer ignores res_valid.

Reset
REQ-026 While rst_n=0: state SHALL be IDLE; res_valid, res_id, res_gt, res_lt and res_eq SHALL be 0; both readys SHALL be 0; index SHALL be WIDTH-1; last-grant SHALL be 1.
REQ-027 Reset asserted mid-RUN or in DONE SHALL abort the operation with no res_valid pulse; the first acceptance after deassertion SHALL follow REQ-013..015.

Verification (WIDTH=8)
REQ-028 req0 a=0x80, b=0x7F -> ready at edge 0; res_valid 2 edges later with gt=1, res_id=0 (k=1).
REQ-029 req1 a=0x35, b=0x35 -> res_valid 9 edges after acceptance with eq=1, res_id=1 (k=8).
REQ-030 req0 a=0x12, b=0x13 -> lt=1, k=8; both requesters valid from reset -> grants alternate 0,1,0,1; each ready pulses one cycle per accept.
REQ-031 rst_n pulsed low during RUN (a=0x01, b=0x00) -> no res_valid; outputs read 0; a new request afterward completes normally.
REQ-032 Inputs altered during RUN and valid held high during RUN/DONE -> result reflects the latched operands, and ready stays 0 until IDLE.

Source files
------------

// File: rtl/serial_cmp_sched.sv
// rtl/serial_cmp_sched.sv - two-requester round-robin serial MSB-first magnitude comparator
// A single 1-bit comparator is shared by both requesters; the scan stops at the first differing bit.
module serial_cmp_sched #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req1_ready,
  output logic             res_valid,
  output logic             res_id,
  output logic             res_gt,
  output logic             res_lt,
  output logic             res_eq
);

  localparam int IW = $clog2(WIDTH);
  localparam logic [IW-1:0] IDX_TOP = IW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             id_q, id_d;
  logic             last_q, last_d;
  logic             res_valid_q, res_valid_d;
  logic             res_id_q, res_id_d;
  logic             res_gt_q, res_gt_d;
  logic             res_lt_q, res_lt_d;
  logic             res_eq_q, res_eq_d;
  logic             grant;
  logic             bit_a, bit_b;
  logic             bit_gt, bit_lt, bit_eq;

  // The one shared bit comparator
  assign bit_a  = a_q[idx_q];
  assign bit_b  = b_q[idx_q];
  assign bit_gt = bit_a & ~bit_b;
  assign bit_lt = ~bit_a & bit_b;
  assign bit_eq = ~(bit_a ^ bit_b);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      idx_q       <= IDX_TOP;
      id_q        <= 1'b0;
      last_q      <= 1'b1;
      res_valid_q <= 1'b0;
      res_id_q    <= 1'b0;
      res_gt_q    <= 1'b0;
      res_lt_q    <= 1'b0;
      res_eq_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      idx_q       <= idx_d;
      id_q        <= id_d;
      last_q      <= last_d;
      res_valid_q <= res_valid_d;
      res_id_q    <= res_id_d;
      res_gt_q    <= res_gt_d;
      res_lt_q    <= res_lt_d;
      res_eq_q    <= res_eq_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    idx_d       = idx_q;
    id_d        = id_q;
    last_d      = last_q;
    res_valid_d = 1'b0;
    res_id_d    = res_id_q;
    res_gt_d    = res_gt_q;
    res_lt_d    = res_lt_q;
    res_eq_d    = res_eq_q;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    grant       = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          // On a tie the requester not served last wins
          grant      = (req0_valid && req1_valid) ? ~last_q : req1_valid;
          req0_ready = rst_n & ~grant;
          req1_ready = rst_n & grant;
          a_d        = grant ? req1_a : req0_a;
          b_d        = grant ? req1_b : req0_b;
          id_d       = grant;
          last_d     = grant;
          idx_d      = IDX_TOP;
          state_d    = RUN;
        end
      end
      RUN: begin
        if (!bit_eq || (idx_q == '0)) begin
          res_valid_d = 1'b1;
          res_id_d    = id_q;
          res_gt_d    = bit_gt;
          res_lt_d    = bit_lt;
          res_eq_d    = bit_eq;
          state_d     = DONE;
        end else begin
          idx_d = idx_q - IW'(1);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign res_valid = res_valid_q;
  assign res_id    = res_id_q;
  assign res_gt    = res_gt_q;
  assign res_lt    = res_lt_q;
  assign res_eq    = res_eq_q;

endmodule

// File: tb/tb_serial_cmp_sched.sv
// tb/tb_serial_cmp_sched.sv - directed scoreboard bench for serial_cmp_sched (WIDTH=8)
module tb_serial_cmp_sched;

  typedef struct {
    logic id;
    logic gt;
    logic lt;
    logic eq;
    int   k;
    int   acc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic [7:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic       req0_ready, req1_ready;
  logic       res_valid, res_id, res_gt, res_lt, res_eq;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t sb[$];
  exp_t last_res;
  bit   have_last = 0;

  serial_cmp_sched #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .res_valid(res_valid), .res_id(res_id), .res_gt(res_gt), .res_lt(res_lt), .res_eq(res_eq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic exp_t model(input logic id, input logic [7:0] a, input logic [7:0] b, input int acc);
    exp_t e;
    logic [7:0] x;
    x = a ^ b;
    e.id = id; e.gt = (a > b); e.lt = (a < b); e.eq = (a == b); e.acc = acc; e.k = 8;
    for (int p = 0; p < 8; p++) if (x[p]) e.k = 8 - p;
    return e;
  endfunction

  // Scoreboard consumer: every result pulse must match the oldest accepted request
  always @(negedge clk) begin
    if (!rst_n) begin
      have_last = 0;
      chk("rst_res_valid", int'(res_valid), 0);
    end else if (res_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_res_valid", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("res_id", int'(res_id), int'(e.id));
        chk("res_gt", int'(res_gt), int'(e.gt));
        chk("res_lt", int'(res_lt), int'(e.lt));
        chk("res_eq", int'(res_eq), int'(e.eq));
        chk("onehot", int'(res_gt) + int'(res_lt) + int'(res_eq), 1);
        chk("latency", cyc - e.acc, e.k + 1);
        last_res = e;
        have_last = 1;
      end
    end else if (have_last) begin
      chk("hold", int'({res_id, res_gt, res_lt, res_eq}),
          int'({last_res.id, last_res.gt, last_res.lt, last_res.eq}));
    end
  end

  task automatic request(input logic id, input logic [7:0] a, input logic [7:0] b,
                         input bit hold, output int waited);
    bit found;
    found = 0;
    waited = 0;
    if (id) begin req1_valid = 1; req1_a = a; req1_b = b; end
    else    begin req0_valid = 1; req0_a = a; req0_b = b; end
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (id ? req1_ready : req0_ready) begin
        found = 1;
        waited = i;
        chk("other_ready_low", int'(id ? req0_ready : req1_ready), 0);
        sb.push_back(model(id, a, b, cyc));
      end
    end
    if (!found) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    if (!hold) begin
      if (id) req1_valid = 0; else req0_valid = 0;
    end
  endtask

  logic [7:0] ta[4] = '{8'h80, 8'h35, 8'h12, 8'h0F};
  logic [7:0] tb[4] = '{8'h7F, 8'h35, 8'h13, 8'h10};

  initial begin
    int  w;
    bit  got;
    int  nxt0, nxt1;

    // Reset state, with both valids raised to prove ready is suppressed
    req0_valid = 1; req1_valid = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready0", int'(req0_ready), 0);
    chk("rst_ready1", int'(req1_ready), 0);
    chk("rst_res_id", int'(res_id), 0);
    chk("rst_res_gt", int'(res_gt), 0);
    chk("rst_res_lt", int'(res_lt), 0);
    chk("rst_res_eq", int'(res_eq), 0);
    req0_valid = 0; req1_valid = 0;
    @(posedge clk); #1 rst_n = 1;
    @(posedge clk); #1;

    // k=1 gt, k=8 eq, k=8 lt
    request(1'b0, 8'h80, 8'h7F, 0, w);
    chk("immediate_ready_gt", w, 0);
    repeat (3) @(posedge clk); #1;
    request(1'b1, 8'h35, 8'h35, 0, w);
    chk("immediate_ready_eq", w, 0);
    repeat (10) @(posedge clk); #1;
    request(1'b0, 8'h12, 8'h13, 0, w);
    repeat (10) @(posedge clk); #1;

    // Reset in the middle of RUN: no pulse, results cleared
    request(1'b0, 8'h01, 8'h00, 0, w);
    repeat (2) @(posedge clk); #1;
    rst_n = 0;
    sb.delete();
    #1;
    chk("midrun_res_valid", int'(res_valid), 0);
    chk("midrun_res_lt", int'(res_lt), 0);
    chk("midrun_res_id", int'(res_id), 0);
    req0_valid = 1; req0_a = ta[0]; req0_b = tb[0];
    req1_valid = 1; req1_a = ta[1]; req1_b = tb[1];
    #1;
    chk("midrun_ready0", int'(req0_ready), 0);
    chk("midrun_ready1", int'(req1_ready), 0);
    repeat (2) @(posedge clk); #1 rst_n = 1;

    // Both valid from reset: grants alternate 0,1,0,1
    nxt0 = 2; nxt1 = 3;
    for (int g = 0; g < 4; g++) begin
      got = 0;
      for (int i = 0; i < 40 && !got; i++) begin
        @(negedge clk);
        if (req0_ready || req1_ready) begin
          got = 1;
          chk("tie_one_ready", int'(req0_ready & req1_ready), 0);
          chk("tie_grant", int'(req1_ready), g % 2);
          if (req1_ready) sb.push_back(model(1'b1, req1_a, req1_b, cyc));
          else            sb.push_back(model(1'b0, req0_a, req0_b, cyc));
        end
      end
      if (!got) chk("tie_timeout", 0, 1);
      @(posedge clk); #1;
      if (g % 2 == 0) begin
        if (g == 2) req0_valid = 0; else begin req0_a = ta[nxt0]; req0_b = tb[nxt0]; end
      end else begin
        if (g == 3) req1_valid = 0; else begin req1_a = ta[nxt1]; req1_b = tb[nxt1]; end
      end
      @(negedge clk);
      chk("ready_pulse0", int'(req0_ready), 0);
      chk("ready_pulse1", int'(req1_ready), 0);
    end
    repeat (12) @(posedge clk); #1;

    // Operands changed and valid held during RUN/DONE
    request(1'b0, 8'h01, 8'h00, 1, w);
    req0_a = 8'h00; req0_b = 8'hFF;
    for (int n = 1; n <= 9; n++) begin
      @(negedge clk);
      chk("busy_ready0", int'(req0_ready), 0);
    end
    @(negedge clk);
    chk("reaccept_ready0", int'(req0_ready), 1);
    if (req0_ready) sb.push_back(model(1'b0, req0_a, req0_b, cyc));
    @(posedge clk); #1 req0_valid = 0;

    for (int i = 0; i < 40 && sb.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    chk("drain", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
